// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage RV32I core.
//
// It watches the IF/ID, ID/EX and EX/MEM instructions, the EX-stage redirect
// and the data-memory ready handshake. From these it drives the hold, bubble,
// flush and freeze controls of the stage registers. It also tracks the length
// of each memory wait, with a sticky timeout flag, and keeps saturating
// stall and flush counters for bring-up.
//
// Ports:
//   clk         core clock; all state updates on the falling edge
//   rst         asynchronous, active-high reset
//   id_inst     instruction in the IF/ID register
//   ex_inst     instruction in the ID/EX register
//   mem_inst    instruction in the EX/MEM register
//   br_taken    EX-stage redirect (taken branch, jal, jalr)
//   dmem_ready  data memory has completed the current access
//   hold_pc     PC keeps its value
//   hold_ifid   IF/ID keeps inst and pc
//   bubble_idex ID/EX loads a NOP and zero operands
//   flush_ifid  IF/ID loads a NOP
//   freeze      PC and every stage register hold
//   mem_err     sticky memory-wait timeout flag
//   stall_cnt   cycles with hold_pc or freeze high (saturating)
//   flush_cnt   cycles with flush_ifid high (saturating)
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      ex_inst,
    input  logic [31:0]      mem_inst,
    input  logic             br_taken,
    input  logic             dmem_ready,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic {RUN, MEMWAIT} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    // Decode helpers take the whole instruction word.
    function automatic logic is_load(input logic [31:0] inst);
        return inst[6:0] == OP_LOAD;
    endfunction

    function automatic logic is_memop(input logic [31:0] inst);
        return (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
    endfunction

    function automatic logic uses_rs1(input logic [31:0] inst);
        return (inst[6:0] == OP_REG)   || (inst[6:0] == OP_IMM) ||
               (inst[6:0] == OP_LOAD)  || (inst[6:0] == OP_STORE) ||
               (inst[6:0] == OP_BR)    || (inst[6:0] == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] inst);
        return (inst[6:0] == OP_REG) || (inst[6:0] == OP_STORE) ||
               (inst[6:0] == OP_BR);
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    logic mem_stall;
    logic loaduse;

    assign mem_stall = is_memop(mem_inst) && !dmem_ready;

    // A load into x0 never creates a dependency.
    assign loaduse = is_load(ex_inst) && (rd_of(ex_inst) != 5'd0) &&
                     ((uses_rs1(id_inst) && (rd_of(ex_inst) == id_inst[19:15])) ||
                      (uses_rs2(id_inst) && (rd_of(ex_inst) == id_inst[24:20])));

    // Priority: memory freeze, then redirect, then load-use. A redirect
    // overrides load-use because the consumer in IF/ID is on the wrong path.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze      = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                freeze = 1'b1;
            end else if (br_taken) begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else if (loaduse) begin
                hold_pc     = 1'b1;
                hold_ifid   = 1'b1;
                bubble_idex = 1'b1;
            end
        end
    end

    // Memory-wait tracker. mem_err is set on the edge that brings wait_cnt
    // to MEM_TIMEOUT, so it is compared against the value being loaded.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEMWAIT;
                        wait_cnt <= WAIT_ONE;
                        if (WAIT_ONE == WAIT_MAX) mem_err <= 1'b1;
                    end
                end
                MEMWAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                        if ((wait_cnt + WAIT_ONE) == WAIT_MAX) mem_err <= 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Bring-up counters, saturating at all-ones.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((hold_pc || freeze) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_ifid && (flush_cnt != '1))          flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
